// File: rtl/vram_write_arbiter.sv
// Shares one single-port synchronous VRAM between display scan reads, a full-frame
// clear sweep and buffered CPU pixel writes; scan reads always win the port.
module vram_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLOR_W    = 3,
  parameter int ROW_W      = 8,
  parameter int COL_W      = 8,
  parameter int ROWS       = 240,
  parameter int COLS       = 256,
  parameter int ADDR_W     = 16
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        iWrValid,
  input  logic [COLOR_W-1:0]          iWrColor,
  input  logic [ROW_W-1:0]            iWrRow,
  input  logic [COL_W-1:0]            iWrCol,
  output logic                        oWrReady,
  input  logic                        iScanReq,
  input  logic [ADDR_W-1:0]           iScanAddr,
  output logic [COLOR_W-1:0]          oScanData,
  output logic                        oScanValid,
  input  logic                        iClear,
  input  logic [COLOR_W-1:0]          iClearColor,
  output logic                        oBusy,
  output logic [ADDR_W-1:0]           oRamAddr,
  output logic                        oRamWe,
  output logic [COLOR_W-1:0]          oRamWrData,
  input  logic [COLOR_W-1:0]          iRamRdData,
  output logic [$clog2(FIFO_DEPTH):0] oFifoLevel,
  output logic                        oDropped,
  output logic                        oRangeErr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [31:0] ROWS_U = 32'(ROWS);
  localparam logic [31:0] COLS_U = 32'(COLS);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(ROWS * COLS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [COLOR_W-1:0] fifo_color [FIFO_DEPTH];
  logic [ROW_W-1:0]   fifo_row   [FIFO_DEPTH];
  logic [COL_W-1:0]   fifo_col   [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level;

  logic               push, pop;
  logic               slot_scan, slot_clear, slot_write;
  logic [COLOR_W-1:0] head_color;
  logic [ROW_W-1:0]   head_row;
  logic [COL_W-1:0]   head_col;
  logic               head_in_range;
  logic [ADDR_W-1:0]  head_addr;

  logic [ADDR_W-1:0]  clr_cnt;
  logic [COLOR_W-1:0] clr_color;
  logic               vld_p0, vld_p1;

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
    return ADDR_W'(32'(r) * COLS_U + 32'(c));
  endfunction

  function automatic logic in_frame(input logic [ROW_W-1:0] r,
                                    input logic [COL_W-1:0] c);
    return (32'(r) < ROWS_U) && (32'(c) < COLS_U);
  endfunction

  assign oWrReady   = (level < LVL_W'(FIFO_DEPTH));
  assign oFifoLevel = level;
  assign oBusy      = (state == S_CLEAR);
  assign push       = iWrValid & oWrReady;
  assign pop        = slot_write;

  assign head_color    = fifo_color[rd_ptr];
  assign head_row      = fifo_row[rd_ptr];
  assign head_col      = fifo_col[rd_ptr];
  assign head_in_range = in_frame(head_row, head_col);
  assign head_addr     = lin_addr(head_row, head_col);

  // Slot grant: scan > clear sweep > FIFO drain; the FIFO is frozen while clearing.
  always_comb begin
    slot_scan  = iScanReq;
    slot_clear = !iScanReq && (state == S_CLEAR);
    slot_write = !iScanReq && (state != S_CLEAR) && (level != '0);
    state_nxt  = state;
    case (state)
      S_IDLE:  if (iClear) state_nxt = S_CLEAR;
      S_CLEAR: if (slot_clear && (clr_cnt == CLR_LAST)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_color[wr_ptr] <= iWrColor;
      fifo_row[wr_ptr]   <= iWrRow;
      fifo_col[wr_ptr]   <= iWrCol;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oRamAddr   <= '0;
      oRamWe     <= 1'b0;
      oRamWrData <= '0;
      clr_cnt    <= '0;
      clr_color  <= '0;
      oDropped   <= 1'b0;
      oRangeErr  <= 1'b0;
    end else begin
      oRamWe <= 1'b0;
      if (slot_scan) begin
        oRamAddr <= iScanAddr;
      end else if (slot_clear) begin
        oRamAddr   <= clr_cnt;
        oRamWe     <= 1'b1;
        oRamWrData <= clr_color;
        clr_cnt    <= clr_cnt + ADDR_W'(1);
      end else if (slot_write) begin
        if (head_in_range) begin
          oRamAddr   <= head_addr;
          oRamWe     <= 1'b1;
          oRamWrData <= head_color;
        end else begin
          oRangeErr <= 1'b1;
        end
      end
      if ((state == S_IDLE) && iClear) begin
        clr_cnt   <= '0;
        clr_color <= iClearColor;
      end
      if (iWrValid && !oWrReady) oDropped <= 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      oScanValid <= 1'b0;
      oScanData  <= '0;
    end else begin
      // p0: address on the RAM port
      vld_p0 <= slot_scan;
      // p1: RAM data arriving on iRamRdData
      vld_p1 <= vld_p0;
      // output stage: registered read data
      oScanValid <= vld_p1;
      if (vld_p1) oScanData <= iRamRdData;
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: a full-size frame and a 2x4 frame run side by side
// against a queue-based reference model, plus directed literal expectations.
module tb_vram_write_arbiter;

  logic        Clock;
  logic        rst;
  logic        wr_v;
  logic [2:0]  wr_c;
  logic [7:0]  wr_r;
  logic [7:0]  wr_col;
  logic        scan_req;
  logic [15:0] scan_addr;
  logic        clr [2];
  logic [2:0]  clr_color;

  logic        ready      [2];
  logic [2:0]  scan_data  [2];
  logic        scan_valid [2];
  logic        busy       [2];
  logic [15:0] ram_addr   [2];
  logic        ram_we     [2];
  logic [2:0]  ram_wd     [2];
  logic [2:0]  ram_rd     [2];
  logic [2:0]  level      [2];
  logic        dropped    [2];
  logic        rangeerr   [2];

  logic [2:0]  mem  [2][65536];
  logic [2:0]  mmem [2][65536];

  int n_checks = 0;
  int n_pass   = 0;

  vram_write_arbiter #(.ROWS(240), .COLS(256)) u_big (
    .Clock(Clock), .Reset(rst),
    .iWrValid(wr_v), .iWrColor(wr_c), .iWrRow(wr_r), .iWrCol(wr_col), .oWrReady(ready[0]),
    .iScanReq(scan_req), .iScanAddr(scan_addr), .oScanData(scan_data[0]), .oScanValid(scan_valid[0]),
    .iClear(clr[0]), .iClearColor(clr_color), .oBusy(busy[0]),
    .oRamAddr(ram_addr[0]), .oRamWe(ram_we[0]), .oRamWrData(ram_wd[0]), .iRamRdData(ram_rd[0]),
    .oFifoLevel(level[0]), .oDropped(dropped[0]), .oRangeErr(rangeerr[0])
  );

  vram_write_arbiter #(.ROWS(2), .COLS(4)) u_small (
    .Clock(Clock), .Reset(rst),
    .iWrValid(wr_v), .iWrColor(wr_c), .iWrRow(wr_r), .iWrCol(wr_col), .oWrReady(ready[1]),
    .iScanReq(scan_req), .iScanAddr(scan_addr), .oScanData(scan_data[1]), .oScanValid(scan_valid[1]),
    .iClear(clr[1]), .iClearColor(clr_color), .oBusy(busy[1]),
    .oRamAddr(ram_addr[1]), .oRamWe(ram_we[1]), .oRamWrData(ram_wd[1]), .iRamRdData(ram_rd[1]),
    .oFifoLevel(level[1]), .oDropped(dropped[1]), .oRangeErr(rangeerr[1])
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Synchronous RAM: write on the edge, read data one cycle after the address.
  initial forever begin
    @(posedge Clock);
    for (int i = 0; i < 2; i++) begin
      if (ram_we[i]) mem[i][ram_addr[i]] <= ram_wd[i];
      ram_rd[i] <= mem[i][ram_addr[i]];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0] color;
    logic [7:0] row;
    logic [7:0] col;
  } ent_t;

  ent_t mq [2][$];
  int   m_addr  [2];
  bit   m_known [2];
  bit   m_we    [2];
  int   m_wd    [2];
  bit   m_busy  [2];
  int   m_caddr [2];
  int   m_ccol  [2];
  bit   m_drop  [2];
  bit   m_rerr  [2];
  bit   sh_v    [2][3];
  int   sh_d    [2][3];

  function automatic int rows_of(input int i);
    return (i == 0) ? 240 : 2;
  endfunction

  function automatic int cols_of(input int i);
    return (i == 0) ? 256 : 4;
  endfunction

  task automatic model_reset(input int i);
    mq[i].delete();
    m_addr[i] = 0; m_known[i] = 1'b1; m_we[i] = 1'b0; m_wd[i] = 0;
    m_busy[i] = 1'b0; m_caddr[i] = 0; m_ccol[i] = 0;
    m_drop[i] = 1'b0; m_rerr[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sh_v[i][k] = 1'b0;
      sh_d[i][k] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int   lvl;
    bit   rdy;
    bit   busy_pre;
    int   a;
    ent_t e;
    lvl      = mq[i].size();
    rdy      = (lvl < 4);
    busy_pre = m_busy[i];
    sh_v[i][2] = sh_v[i][1]; sh_d[i][2] = sh_d[i][1];
    sh_v[i][1] = sh_v[i][0]; sh_d[i][1] = sh_d[i][0];
    sh_v[i][0] = 1'b0;
    m_we[i] = 1'b0;
    if (scan_req) begin
      m_addr[i]  = int'(scan_addr);
      m_known[i] = 1'b1;
      sh_v[i][0] = 1'b1;
      sh_d[i][0] = int'(mmem[i][int'(scan_addr)]);
    end else if (busy_pre) begin
      m_addr[i]  = m_caddr[i];
      m_known[i] = 1'b1;
      m_we[i]    = 1'b1;
      m_wd[i]    = m_ccol[i];
      mmem[i][m_caddr[i]] = 3'(m_ccol[i]);
      if (m_caddr[i] == rows_of(i) * cols_of(i) - 1) m_busy[i] = 1'b0;
      else m_caddr[i]++;
    end else if (lvl > 0) begin
      e = mq[i].pop_front();
      if (int'(e.row) < rows_of(i) && int'(e.col) < cols_of(i)) begin
        a = (int'(e.row) * cols_of(i) + int'(e.col)) % 65536;
        m_addr[i]  = a;
        m_known[i] = 1'b1;
        m_we[i]    = 1'b1;
        m_wd[i]    = int'(e.color);
        mmem[i][a] = e.color;
      end else begin
        m_rerr[i]  = 1'b1;
        m_known[i] = 1'b0;
      end
    end
    if (!busy_pre && clr[i]) begin
      m_busy[i]  = 1'b1;
      m_ccol[i]  = int'(clr_color);
      m_caddr[i] = 0;
    end
    if (wr_v) begin
      if (rdy) begin
        e.color = wr_c; e.row = wr_r; e.col = wr_col;
        mq[i].push_back(e);
      end else begin
        m_drop[i] = 1'b1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) model_reset(i);
    forever begin
      @(posedge Clock or posedge rst);
      for (int i = 0; i < 2; i++) begin
        if (rst) model_reset(i);
        else     model_step(i);
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge Clock);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("we[%0d]", i), int'(ram_we[i]), int'(m_we[i]));
      if (m_known[i]) chk($sformatf("addr[%0d]", i), int'(ram_addr[i]), m_addr[i]);
      if (m_we[i])    chk($sformatf("wdata[%0d]", i), int'(ram_wd[i]), m_wd[i]);
      chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(m_busy[i]));
      chk($sformatf("level[%0d]", i), int'(level[i]), mq[i].size());
      chk($sformatf("ready[%0d]", i), int'(ready[i]), int'(mq[i].size() < 4));
      chk($sformatf("dropped[%0d]", i), int'(dropped[i]), int'(m_drop[i]));
      chk($sformatf("rangeerr[%0d]", i), int'(rangeerr[i]), int'(m_rerr[i]));
      chk($sformatf("svalid[%0d]", i), int'(scan_valid[i]), int'(sh_v[i][2]));
      if (sh_v[i][2]) chk($sformatf("sdata[%0d]", i), int'(scan_data[i]), sh_d[i][2]);
    end
  end

  task automatic push_ent(input int c, input int r, input int col);
    wr_v = 1'b1; wr_c = 3'(c); wr_r = 8'(r); wr_col = 8'(col);
  endtask

  // ---------------- directed stimulus ----------------
  int exp_a [4];
  int exp_d [4];
  int pulses, vc, vd, busy_n, last_busy, land_c, land_a, ones_n, we_n;
  int hist [8];
  bit found;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 65536; a++) begin
        mem[i][a]  = 3'(a ^ (a >> 3));
        mmem[i][a] = 3'(a ^ (a >> 3));
      end
    for (int i = 0; i < 2; i++) begin
      mem[i][16'h0100]  = 3'd5;
      mmem[i][16'h0100] = 3'd5;
      clr[i] = 1'b0;
    end
    rst = 1'b1; wr_v = 1'b0; wr_c = '0; wr_r = '0; wr_col = '0;
    scan_req = 1'b0; scan_addr = '0; clr_color = '0;
    repeat (3) @(negedge Clock);
    chk("reset_ready", int'(ready[0]), 1);
    chk("reset_level", int'(level[0]), 0);
    chk("reset_we", int'(ram_we[0]), 0);
    chk("reset_busy", int'(busy[1]), 0);
    rst = 1'b0;

    // single write at (2,5)
    @(negedge Clock); push_ent(3, 2, 5);
    @(negedge Clock); wr_v = 1'b0;
    chk("t1_level_after_push", int'(level[0]), 1);
    @(negedge Clock);
    chk("t1_we", int'(ram_we[0]), 1);
    chk("t1_addr", int'(ram_addr[0]), 517);
    chk("t1_data", int'(ram_wd[0]), 3);
    chk("t1_level_drained", int'(level[0]), 0);

    // writes queued behind a 10-cycle scan burst
    repeat (2) @(negedge Clock);
    we_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      if (k >= 1) we_n += int'(ram_we[0]);
      if (k == 4) chk("t2_ready_full", int'(ready[0]), 0);
      if (k == 5) chk("t2_dropped", int'(dropped[0]), 1);
      scan_req = 1'b1; scan_addr = 16'h0010 + 16'(k);
      case (k)
        0: push_ent(1, 0, 0);
        1: push_ent(2, 0, 1);
        2: push_ent(4, 1, 2);
        3: push_ent(7, 1, 3);
        4: push_ent(3, 0, 0);
        default: wr_v = 1'b0;
      endcase
    end
    @(negedge Clock);
    we_n += int'(ram_we[0]);
    scan_req = 1'b0; wr_v = 1'b0;
    chk("t2_no_write_during_scan", we_n, 0);
    exp_a = '{0, 1, 258, 259};
    exp_d = '{1, 2, 4, 7};
    for (int j = 0; j < 4; j++) begin
      @(negedge Clock);
      chk($sformatf("t2_we_%0d", j), int'(ram_we[0]), 1);
      chk($sformatf("t2_addr_%0d", j), int'(ram_addr[0]), exp_a[j]);
      chk($sformatf("t2_data_%0d", j), int'(ram_wd[0]), exp_d[j]);
    end

    // single scan of 0x0100 returning 5
    repeat (6) @(negedge Clock);
    scan_req = 1'b1; scan_addr = 16'h0100;
    pulses = 0; vc = -1; vd = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clock);
      if (c == 1) scan_req = 1'b0;
      if (scan_valid[0]) begin
        pulses++; vc = c; vd = int'(scan_data[0]);
      end
    end
    chk("t3_pulses", pulses, 1);
    chk("t3_latency", vc, 3);
    chk("t3_data", vd, 5);

    // clear sweep on the 2x4 frame with one scan stall and one queued write
    @(negedge Clock); clr[1] = 1'b1; clr_color = 3'd1;
    busy_n = 0; last_busy = 0; land_c = -1; land_a = -1; ones_n = 0;
    for (int k = 0; k < 8; k++) hist[k] = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge Clock);
      if (busy[1]) begin
        busy_n++; last_busy = c;
      end
      if (ram_we[1]) begin
        if (ram_wd[1] == 3'd1 && ram_addr[1] < 16'd8) begin
          hist[int'(ram_addr[1])]++; ones_n++;
        end else if (ram_wd[1] == 3'd6) begin
          land_c = c; land_a = int'(ram_addr[1]);
        end
      end
      if (c == 1) clr[1] = 1'b0;
      if (c == 2) begin
        scan_req = 1'b1; scan_addr = 16'h0100; push_ent(6, 1, 0);
      end
      if (c == 3) begin
        scan_req = 1'b0; wr_v = 1'b0;
      end
    end
    chk("t4_busy_cycles", busy_n, 9);
    chk("t4_clear_writes", ones_n, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("t4_addr%0d_once", k), hist[k], 1);
    chk("t4_queued_addr", land_a, 4);
    chk("t4_queued_after_busy", int'(land_c > last_busy), 1);

    // out-of-range entry followed by a valid one
    @(negedge Clock); push_ent(2, 240, 0);
    @(negedge Clock);
    chk("t5_rangeerr_before", int'(rangeerr[0]), 0);
    push_ent(5, 3, 4);
    @(negedge Clock); wr_v = 1'b0;
    chk("t5_no_we", int'(ram_we[0]), 0);
    chk("t5_rangeerr", int'(rangeerr[0]), 1);
    @(negedge Clock);
    chk("t5_we", int'(ram_we[0]), 1);
    chk("t5_addr", int'(ram_addr[0]), 772);
    chk("t5_data", int'(ram_wd[0]), 5);

    // asynchronous reset while the sweep writes address 3
    repeat (2) @(negedge Clock);
    clr[1] = 1'b1; clr_color = 3'd4; push_ent(2, 0, 0);
    @(negedge Clock); clr[1] = 1'b0; push_ent(3, 1, 1);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge Clock);
      wr_v = 1'b0;
      if (ram_we[1] && ram_addr[1] == 16'd3) found = 1'b1;
    end
    chk("t6_reached_addr3", int'(found), 1);
    chk("t6_level_before_reset", int'(level[1]), 2);
    #1 rst = 1'b1;
    #1;
    chk("t6_addr", int'(ram_addr[1]), 0);
    chk("t6_we", int'(ram_we[1]), 0);
    chk("t6_wdata", int'(ram_wd[1]), 0);
    chk("t6_busy", int'(busy[1]), 0);
    chk("t6_level", int'(level[1]), 0);
    chk("t6_ready", int'(ready[1]), 1);
    chk("t6_svalid", int'(scan_valid[1]), 0);
    chk("t6_sdata", int'(scan_data[1]), 0);
    chk("t6_dropped", int'(dropped[1]), 0);
    chk("t6_rangeerr", int'(rangeerr[1]), 0);
    repeat (2) @(negedge Clock);
    rst = 1'b0;
    we_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      we_n += int'(ram_we[1]);
    end
    chk("t6_no_we_after_release", we_n, 0);
    chk("t6_idle_after_release", int'(busy[1]), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
